// File: rtl/bcd_counter3.sv
// rtl/bcd_counter3.sv - three-digit BCD up/down counter with prescaler and load
// Down counting is built only when BCD_COUNTER3_DOWN_EN is defined.
module bcd_counter3 #(
  parameter int unsigned DIV = 10000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        up_dn,
  input  logic        load,
  input  logic [11:0] load_val,
  output logic [11:0] digits,
  output logic        tick,
  output logic        carry
);

  localparam logic [23:0] LAST = 24'(DIV - 1);

  logic [23:0] presc;

  logic [3:0] u, t, h;
  assign u = digits[3:0];
  assign t = digits[7:4];
  assign h = digits[11:8];

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // Per-nibble BCD increment: a digit only advances when all lower digits wrap
  logic        u9, t9, h9;
  logic [11:0] inc_val;
  logic        inc_wrap;
  assign u9 = (u == 4'd9);
  assign t9 = (t == 4'd9);
  assign h9 = (h == 4'd9);
  assign inc_val[3:0]  = u9 ? 4'd0 : u + 4'd1;
  assign inc_val[7:4]  = u9 ? (t9 ? 4'd0 : t + 4'd1) : t;
  assign inc_val[11:8] = (u9 && t9) ? (h9 ? 4'd0 : h + 4'd1) : h;
  assign inc_wrap      = u9 && t9 && h9;

  logic [11:0] next_val;
  logic        next_wrap;

`ifdef BCD_COUNTER3_DOWN_EN
  logic        u0, t0, h0;
  logic [11:0] dec_val;
  logic        dec_wrap;
  assign u0 = (u == 4'd0);
  assign t0 = (t == 4'd0);
  assign h0 = (h == 4'd0);
  assign dec_val[3:0]  = u0 ? 4'd9 : u - 4'd1;
  assign dec_val[7:4]  = u0 ? (t0 ? 4'd9 : t - 4'd1) : t;
  assign dec_val[11:8] = (u0 && t0) ? (h0 ? 4'd9 : h - 4'd1) : h;
  assign dec_wrap      = u0 && t0 && h0;

  // up_dn is only consulted here, i.e. when a step actually lands
  assign next_val  = up_dn ? inc_val : dec_val;
  assign next_wrap = up_dn ? inc_wrap : dec_wrap;
`else
  logic unused_up_dn;
  assign unused_up_dn = up_dn;
  assign next_val     = inc_val;
  assign next_wrap    = inc_wrap;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc  <= 24'd0;
      digits <= 12'h000;
      tick   <= 1'b0;
      carry  <= 1'b0;
    end else if (load) begin
      presc  <= 24'd0;
      digits <= {clamp9(load_val[11:8]), clamp9(load_val[7:4]), clamp9(load_val[3:0])};
      tick   <= 1'b0;
      carry  <= 1'b0;
    end else if (en) begin
      if (presc == LAST) begin
        presc  <= 24'd0;
        digits <= next_val;
        tick   <= 1'b1;
        carry  <= next_wrap;
      end else begin
        presc  <= presc + 24'd1;
        tick   <= 1'b0;
        carry  <= 1'b0;
      end
    end else begin
      tick  <= 1'b0;
      carry <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_counter3.sv
// tb/tb_bcd_counter3.sv - vector-table bench for bcd_counter3 (DIV=4 and DIV=1 instances)
module tb_bcd_counter3;

  logic        clk = 1'b0;
  logic        rst_n, en, up_dn, load;
  logic [11:0] load_val;
  logic [11:0] d4, d1;
  logic        t4, t1, c4, c1;

  always #5 clk = ~clk;

  bcd_counter3 #(.DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .digits(d4), .tick(t4), .carry(c4)
  );

  bcd_counter3 #(.DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .digits(d1), .tick(t1), .carry(c1)
  );

  typedef struct {
    string       name;
    bit          sel1;
    logic        rst_n, en, up_dn, load;
    logic [11:0] load_val;
    logic [11:0] exp_digits;
    logic        exp_tick, exp_carry;
  } vec_t;

  typedef struct {
    string       name;
    bit          sel1;
    logic [11:0] digits;
    logic        tick, carry;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input string name, input bit sel1, input logic r, input logic e,
                     input logic ud, input logic ld, input logic [11:0] lv,
                     input logic [11:0] ed, input logic et, input logic ec);
    vec_t v;
    v.name = name; v.sel1 = sel1; v.rst_n = r; v.en = e; v.up_dn = ud; v.load = ld;
    v.load_val = lv; v.exp_digits = ed; v.exp_tick = et; v.exp_carry = ec;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    exp_t e, got;
    @(negedge clk);
    rst_n = v.rst_n; en = v.en; up_dn = v.up_dn; load = v.load; load_val = v.load_val;
    e.name = v.name; e.sel1 = v.sel1;
    e.digits = v.exp_digits; e.tick = v.exp_tick; e.carry = v.exp_carry;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checks++;
    if (got.sel1 ? (d1 !== got.digits || t1 !== got.tick || c1 !== got.carry)
                 : (d4 !== got.digits || t4 !== got.tick || c4 !== got.carry)) begin
      failures++;
      $display("FAIL %s: got digits=%03h tick=%b carry=%b, expected digits=%03h tick=%b carry=%b",
               got.name, got.sel1 ? d1 : d4, got.sel1 ? t1 : t4, got.sel1 ? c1 : c4,
               got.digits, got.tick, got.carry);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 12'h000;

    // reset state of both instances, reset beating load and en
    add("reset_div4", 0, 0, 1, 1, 1, 12'h555, 12'h000, 0, 0);
    add("reset_div1", 1, 0, 1, 1, 1, 12'h555, 12'h000, 0, 0);

    // DIV=4 free run: tick on cycles 4, 8, 12
    for (int i = 1; i <= 12; i++)
      add("div4_run", 0, 1, 1, 1, 0, 12'h000, 12'(i / 4), (i % 4) == 0, 0);

    // DIV=1: 998 -> 999 -> 000 with carry only on the wrap cycle, then freeze
    add("div1_load998", 1, 1, 0, 1, 1, 12'h998, 12'h998, 0, 0);
    add("div1_999",     1, 1, 1, 1, 0, 12'h000, 12'h999, 1, 0);
    add("div1_wrap",    1, 1, 1, 1, 0, 12'h000, 12'h000, 1, 1);
    add("div1_hold",    1, 1, 0, 1, 0, 12'h000, 12'h000, 0, 0);
    add("div1_hold2",   1, 1, 0, 1, 0, 12'h000, 12'h000, 0, 0);

    // load clamps nibbles and overrides a simultaneous step
    add("clamp_a3f",      1, 1, 0, 1, 1, 12'hA3F, 12'h939, 0, 0);
    add("load_over_step", 1, 1, 1, 1, 1, 12'h555, 12'h555, 0, 0);
    add("tens_carry",     1, 1, 0, 1, 1, 12'h199, 12'h199, 0, 0);
    add("tens_carry_up",  1, 1, 1, 1, 0, 12'h000, 12'h200, 1, 0);

    // down counting, or ignored up_dn when the feature is not built
    add("dn_load001", 1, 1, 0, 0, 1, 12'h001, 12'h001, 0, 0);
`ifdef BCD_COUNTER3_DOWN_EN
    add("dn_000", 1, 1, 1, 0, 0, 12'h000, 12'h000, 1, 0);
    add("dn_999", 1, 1, 1, 0, 0, 12'h000, 12'h999, 1, 1);
    add("dn_998", 1, 1, 1, 0, 0, 12'h000, 12'h998, 1, 0);
    add("dn_load300", 1, 1, 0, 0, 1, 12'h300, 12'h300, 0, 0);
    add("dn_borrow",  1, 1, 1, 0, 0, 12'h000, 12'h299, 1, 0);
`else
    add("dn_ign_002", 1, 1, 1, 0, 0, 12'h000, 12'h002, 1, 0);
    add("dn_ign_003", 1, 1, 1, 0, 0, 12'h000, 12'h003, 1, 0);
    add("dn_ign_004", 1, 1, 1, 0, 0, 12'h000, 12'h004, 1, 0);
`endif

    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();

    // DIV=4: load on a step cycle suppresses the tick and restarts the interval
    add("ld_step_rst", 0, 0, 0, 1, 0, 12'h000, 12'h000, 0, 0);
    for (int i = 0; i < 3; i++) add("ld_step_pre", 0, 1, 1, 1, 0, 12'h000, 12'h000, 0, 0);
    add("ld_step_load", 0, 1, 1, 1, 1, 12'h5FC, 12'h599, 0, 0);
    for (int i = 0; i < 3; i++) add("ld_step_wait", 0, 1, 1, 1, 0, 12'h000, 12'h599, 0, 0);
    add("ld_step_600", 0, 1, 1, 1, 0, 12'h000, 12'h600, 1, 0);

    // DIV=4: pause at prescaler=2, resume needs exactly two more enabled cycles
    add("pause_rst", 0, 0, 0, 1, 0, 12'h000, 12'h000, 0, 0);
    for (int i = 0; i < 2; i++) add("pause_pre", 0, 1, 1, 1, 0, 12'h000, 12'h000, 0, 0);
    for (int i = 0; i < 10; i++) add("pause_off", 0, 1, 0, 1, 0, 12'h000, 12'h000, 0, 0);
    add("pause_res1", 0, 1, 1, 1, 0, 12'h000, 12'h000, 0, 0);
    add("pause_res2", 0, 1, 1, 1, 0, 12'h000, 12'h001, 1, 0);

    // DIV=4: reset at prescaler=3 with load discards the partial interval
    add("rmid_rst", 0, 0, 0, 1, 0, 12'h000, 12'h000, 0, 0);
    for (int i = 0; i < 3; i++) add("rmid_pre", 0, 1, 1, 1, 0, 12'h000, 12'h000, 0, 0);
    add("rmid_reset", 0, 0, 1, 1, 1, 12'h123, 12'h000, 0, 0);
    for (int i = 0; i < 3; i++) add("rmid_wait", 0, 1, 1, 1, 0, 12'h000, 12'h000, 0, 0);
    add("rmid_tick", 0, 1, 1, 1, 0, 12'h000, 12'h001, 1, 0);

    foreach (vecs[i]) apply(vecs[i]);

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_counter3.md
BCD_COUNTER3 -- requirements
Module: bcd_counter3

Interface
REQ-001 SHALL have parameter DIV, default 10000000, meaning clock cycles per count step (legal range 1..2^24-1).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port en  input  1  count enable; 0 freezes prescaler and digits.
REQ-005 SHALL have port up_dn  input  1  direction, 1=up, 0=down (see Configuration).
REQ-006 SHALL have port load  input  1  synchronous load strobe.
REQ-007 SHALL have port load_val  input  12  BCD value to load, [11:8]=hundreds, [7:4]=tens, [3:0]=units.
REQ-008 SHALL have port digits  output  12  registered BCD count, same packing as load_val, feeding the 3-digit 7-segment scan stage.
REQ-009 SHALL have port tick  output  1  registered one-cycle pulse per count step.
REQ-010 SHALL have port carry  output  1  registered one-cycle pulse on wrap (999->000 up, 000->999 down).

Function
REQ-011 SHALL hold a 24-bit prescaler counting 0..DIV-1 while en=1; at DIV-1 it returns to 0 and issues a step.
REQ-012 SHALL, on a step edge, update digits and assert tick for exactly the following cycle (digits and tick change on the same edge).
REQ-013 SHALL, with DIV=1, step on every enabled cycle (tick held high continuously).
REQ-014 SHALL increment up: units 9->0 carries into tens, tens 9->0 into hundreds; 999 -> 000 asserts carry in the same cycle digits first read 000.
REQ-015 SHALL decrement down: units 0->9 borrows from tens, tens 0->9 from hundreds; 000 -> 999 asserts carry in the same cycle digits first read 999.
REQ-016 SHALL keep every digit nibble in 0..9 at all times; arithmetic is per-nibble BCD, never binary 12-bit.
REQ-017 SHALL, when en=0, hold prescaler, digits; tick and carry deassert next cycle.
REQ-018 SHALL, when load=1, on that edge set digits to load_val, clear prescaler to 0, force tick=0 and carry=0; load overrides en and any simultaneous step.
REQ-019 SHALL clamp any load_val nibble above 9 to 9 (e.g. 12'hA3F loads 939).
REQ-020 SHALL sample up_dn only at step edges; a direction change mid-interval affects the next step only, prescaler unaffected.

Reset
REQ-021 SHALL, on any clk edge with rst_n=0, set digits=000, prescaler=0, tick=0, carry=0; reset overrides load and en.
REQ-022 SHALL resume counting from prescaler 0 on the first edge with rst_n=1 and en=1; reset mid-interval discards the partial interval.

Configuration
REQ-023 SHALL use macro BCD_COUNTER3_DOWN_EN: defined -> up_dn honoured per REQ-015/REQ-020.
REQ-024 SHALL, with BCD_COUNTER3_DOWN_EN undefined, keep port up_dn present but ignored, count up only, and contain no decrement logic.

Verification
REQ-025 SHALL cover: DIV=4, reset then en=1 for 12 cycles -> tick on cycles 4,8,12; digits 001,002,003.
REQ-026 SHALL cover: DIV=1, load 12'h998 then en=1 for 2 cycles -> digits 999 then 000 with carry=1 only in the 000 cycle.
REQ-027 SHALL cover: DIV=4, en=1, load 12'h5FC asserted on a step cycle -> digits 599, tick=0, next tick exactly 4 cycles later giving 600.
REQ-028 SHALL cover: DIV=4, count to prescaler=2, en=0 for 10 cycles, en=1 -> step after 2 more enabled cycles, no tick while en=0.
REQ-029 SHALL cover (macro defined): DIV=1, load 12'h001, up_dn=0 for 3 cycles -> 000, 999 (carry=1), 998; macro undefined, same stimulus -> 002, 003, 004.
REQ-030 SHALL cover: DIV=4, rst_n=0 for one cycle at prescaler=3 with load=1 -> digits 000, no tick, first tick 4 cycles after release.
